// File: rtl/uart_rx_fsm_if.sv
// uart_rx_fsm_if: serial line, frame configuration and received-byte outputs of uart_rx_fsm.
interface uart_rx_fsm_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic                  rx_in;
    logic                  par_en;
    logic                  par_typ;
    logic [DATA_WIDTH-1:0] p_data;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;
    logic                  busy;
    modport master (output rx_in, par_en, par_typ, input p_data, data_valid, par_err, stp_err, busy);
    modport slave (input rx_in, par_en, par_typ, output p_data, data_valid, par_err, stp_err, busy);
endinterface

// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: oversampled UART receiver (start, LSB-first data, optional parity, one stop bit).
// Define UART_RX_MAJORITY_EN to decide each bit by a 2-of-3 vote around mid-bit.
module uart_rx_fsm #(
    parameter int PRESCALE   = 8,
    parameter int DATA_WIDTH = 8
) (
    input logic          clk,
    input logic          rest,
    uart_rx_fsm_if.slave bus
);
    localparam int EW = $clog2(PRESCALE);
    localparam int BW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t                state_q, state_d;
    logic [EW-1:0]         edge_q, edge_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d, p_data_q, p_data_d;
    logic                  par_en_q, par_en_d, par_typ_q, par_typ_d;
    logic                  perr_q, perr_d, stp_q, stp_d;
    logic                  valid_q, valid_d, par_err_q, par_err_d, stp_err_q, stp_err_d;
    logic                  bit_v, at_sp, at_end, stp_now;
`ifdef UART_RX_MAJORITY_EN
    localparam int SP = PRESCALE / 2 + 1;
    logic [1:0] samp_q;
    always_ff @(posedge clk) samp_q <= rest ? 2'b00 : {samp_q[0], bus.rx_in};
    assign bit_v = (samp_q[1] & samp_q[0]) | ((samp_q[1] | samp_q[0]) & bus.rx_in);
`else
    localparam int SP = PRESCALE / 2;
    assign bit_v = bus.rx_in;
`endif
    assign at_sp   = edge_q == EW'(SP);
    assign at_end  = edge_q == EW'(PRESCALE - 1);
    // With a short prescale the stop decision can land on the final count itself
    assign stp_now = at_sp ? bit_v : stp_q;
    assign bus.p_data     = p_data_q;
    assign bus.data_valid = valid_q;
    assign bus.par_err    = par_err_q;
    assign bus.stp_err    = stp_err_q;
    assign bus.busy       = state_q != IDLE;
    always_ff @(posedge clk) begin
        if (rest) begin
            state_q   <= IDLE;
            edge_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            p_data_q  <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            perr_q    <= 1'b0;
            stp_q     <= 1'b0;
            valid_q   <= 1'b0;
            par_err_q <= 1'b0;
            stp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            edge_q    <= edge_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            p_data_q  <= p_data_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            perr_q    <= perr_d;
            stp_q     <= stp_d;
            valid_q   <= valid_d;
            par_err_q <= par_err_d;
            stp_err_q <= stp_err_d;
        end
    end
    always_comb begin
        state_d   = state_q;
        edge_d    = at_end ? '0 : edge_q + 1'b1;
        bit_d     = bit_q;
        shift_d   = shift_q;
        p_data_d  = p_data_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        perr_d    = perr_q;
        stp_d     = stp_q;
        valid_d   = 1'b0;
        par_err_d = 1'b0;
        stp_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                // The detecting cycle is count 0 of the start bit
                edge_d = EW'(1);
                if (!bus.rx_in) begin
                    state_d   = START;
                    par_en_d  = bus.par_en;
                    par_typ_d = bus.par_typ;
                    perr_d    = 1'b0;
                    bit_d     = '0;
                end
            end
            START: begin
                if (at_sp && bit_v) state_d = IDLE;
                else if (at_end) state_d = DATA;
            end
            DATA: begin
                if (at_sp) shift_d = {bit_v, shift_q[DATA_WIDTH-1:1]};
                if (at_end) begin
                    bit_d = bit_q + 1'b1;
                    if (bit_q == BW'(DATA_WIDTH - 1)) begin
                        bit_d   = '0;
                        state_d = par_en_q ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (at_sp) perr_d = bit_v ^ (^shift_q) ^ par_typ_q;
                if (at_end) state_d = STOP;
            end
            STOP: begin
                if (at_sp) stp_d = bit_v;
                if (at_end) begin
                    state_d   = IDLE;
                    valid_d   = !perr_q && stp_now;
                    par_err_d = perr_q;
                    stp_err_d = !stp_now;
                    p_data_d  = valid_d ? shift_q : p_data_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb_uart_rx_fsm: frame-level reference model plus directed and randomized frames for uart_rx_fsm.
module tb_uart_rx_fsm;
    localparam int P = 8;
    localparam int H = P / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam bit MAJ = 1'b1;
`else
    localparam bit MAJ = 1'b0;
`endif
    localparam int DEC = MAJ ? H + 1 : H;
    logic clk = 1'b0;
    logic rest;
    uart_rx_fsm_if #(.DATA_WIDTH(8)) bus ();
    uart_rx_fsm #(.PRESCALE(P), .DATA_WIDTH(8)) dut (.clk(clk), .rest(rest), .bus(bus));
    always #5 clk = ~clk;
    int total = 0, bad = 0, cyc = 0, t0_drv = 0;
    int n_pe = 0, n_se = 0, last_pe = 0, last_se = 0;
    int vq_cyc[$];
    logic [7:0] vq_dat[$];
    logic hist [0:16383];
    int t0 = -1;
    logic mpe, mpt, m_valid, m_perr, m_serr, m_busy;
    logic [7:0] m_pdata, md;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask
    // Bit value of the bit whose first cycle is s, from the recorded line
    function automatic logic bitval(input int s);
        if (MAJ) return (hist[s+H-1] & hist[s+H]) | (hist[s+H-1] & hist[s+H+1]) | (hist[s+H] & hist[s+H+1]);
        return hist[s+H];
    endfunction
    initial begin
        m_valid = 0; m_perr = 0; m_serr = 0; m_busy = 0; m_pdata = 0; mpe = 0; mpt = 0; md = 0;
        forever begin
            @(posedge clk);
            hist[cyc] = bus.rx_in;
            m_valid = 0; m_perr = 0; m_serr = 0;
            if (rest) begin
                t0 = -1;
                m_pdata = 0;
            end else if (t0 < 0) begin
                if (!bus.rx_in) begin
                    t0 = cyc; mpe = bus.par_en; mpt = bus.par_typ;
                end
            end else if (cyc - t0 == DEC && bitval(t0)) begin
                t0 = -1;
            end else if (cyc - t0 == (mpe ? 11 : 10) * P - 1) begin
                for (int i = 0; i < 8; i++) md[i] = bitval(t0 + (i + 1) * P);
                m_perr = mpe && (bitval(t0 + 9 * P) != ((^md) ^ mpt));
                m_serr = !bitval(t0 + (mpe ? 10 : 9) * P);
                m_valid = !m_perr && !m_serr;
                if (m_valid) m_pdata = md;
                t0 = -1;
            end
            m_busy = t0 >= 0;
            cyc = cyc + 1;
        end
    end
    initial forever begin
        @(negedge clk);
        if (bus.data_valid) begin vq_cyc.push_back(cyc); vq_dat.push_back(bus.p_data); end
        if (bus.par_err) begin n_pe++; last_pe = cyc; end
        if (bus.stp_err) begin n_se++; last_se = cyc; end
        if (cyc > 0) begin
            chk("valid", bus.data_valid, m_valid);
            chk("par_err", bus.par_err, m_perr);
            chk("stp_err", bus.stp_err, m_serr);
            chk("busy", bus.busy, m_busy);
            chk("p_data", bus.p_data, m_pdata);
        end
    end
    task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic bad_par, input logic stop,
                        input int glitch_at, input int rst_at, input int gap, input logic scr);
        logic [10:0] bits;
        int l;
        l = pe ? 11 : 10;
        bits = pe ? {stop, (^d) ^ pt ^ bad_par, d, 1'b0} : {1'b1, stop, d, 1'b0};
        bus.par_en = pe; bus.par_typ = pt;
        t0_drv = cyc;
        for (int j = 0; j < l * P; j++) begin
            if (j == rst_at) begin
                rest = 1; bus.rx_in = 1;
                @(negedge clk);
                rest = 0;
                return;
            end
            bus.rx_in = bits[j/P] ^ (j == glitch_at);
            if (scr && j == 1) begin bus.par_en = 1'($urandom); bus.par_typ = 1'($urandom); end
            @(negedge clk);
        end
        bus.rx_in = 1;
        repeat (gap) @(negedge clk);
    endtask
    int nv, ne, v1, l;
    initial begin
        rest = 1; bus.rx_in = 1; bus.par_en = 0; bus.par_typ = 0;
        repeat (3) @(negedge clk);
        chk("rst_pdata", bus.p_data, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_valid", bus.data_valid, 0);
        rest = 0;
        repeat (2) @(negedge clk);
        nv = vq_cyc.size(); ne = n_pe + n_se;
        send(8'hA5, 0, 0, 0, 1, -1, -1, 2, 0);
        chk("t1_count", vq_cyc.size(), nv + 1);
        chk("t1_latency", vq_cyc[$] - t0_drv, 80);
        chk("t1_data", bus.p_data, 8'hA5);
        chk("t1_model", m_pdata, 8'hA5);
        chk("t1_errs", n_pe + n_se, ne);
        send(8'h3C, 1, 0, 0, 1, -1, -1, 2, 0);
        chk("t2_latency", vq_cyc[$] - t0_drv, 88);
        chk("t2_data", vq_dat[$], 8'h3C);
        nv = vq_cyc.size(); ne = n_pe;
        send(8'h3C, 1, 0, 1, 1, -1, -1, 2, 0);
        chk("t2_perr_count", n_pe, ne + 1);
        chk("t2_perr_latency", last_pe - t0_drv, 88);
        chk("t2_no_valid", vq_cyc.size(), nv);
        chk("t2_hold", bus.p_data, 8'h3C);
        nv = vq_cyc.size(); ne = n_pe; l = n_se;
        send(8'h01, 1, 1, 0, 0, -1, -1, 2, 0);
        chk("t3_serr", n_se, l + 1);
        chk("t3_no_perr", n_pe, ne);
        chk("t3_no_valid", vq_cyc.size(), nv);
        nv = vq_cyc.size(); ne = n_pe + n_se; t0_drv = cyc;
        bus.rx_in = 0;
        @(negedge clk);
        chk("t4_busy_hi", bus.busy, 1);
        repeat (2) @(negedge clk);
        bus.rx_in = 1;
        repeat (MAJ ? 3 : 2) @(negedge clk);
        chk("t4_busy_lo", bus.busy, 0);
        repeat (4) @(negedge clk);
        chk("t4_no_pulse", vq_cyc.size() + n_pe + n_se, nv + ne);
        send(8'h55, 0, 0, 0, 1, -1, -1, 2, 0);
        chk("t4_data", bus.p_data, 8'h55);
        send(8'h12, 0, 0, 0, 1, -1, -1, 0, 0);
        v1 = vq_cyc[$];
        chk("t5_first", vq_dat[$], 8'h12);
        send(8'h34, 0, 0, 0, 1, -1, -1, 2, 0);
        chk("t5_spacing", vq_cyc[$] - v1, 80);
        chk("t5_second", bus.p_data, 8'h34);
        send(8'h77, 0, 0, 0, 1, -1, 40, 0, 0);
        chk("t6_busy", bus.busy, 0);
        chk("t6_pdata", bus.p_data, 0);
        chk("t6_valid", bus.data_valid, 0);
        repeat (2) @(negedge clk);
        send(8'hFF, 0, 0, 0, 1, -1, -1, 2, 0);
        chk("t6_ff", bus.p_data, 8'hFF);
        send(8'h00, 0, 0, 0, 1, 4 * P + H, -1, 2, 0);
        chk("t6_glitch", bus.p_data, MAJ ? 8'h00 : 8'h08);
        for (int k = 0; k < 60; k++) begin
            logic pe;
            pe = 1'($urandom);
            l = (pe ? 11 : 10) * P;
            send(8'($urandom), pe, 1'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 7) != 0,
                 $urandom_range(0, 3) == 0 ? int'($urandom_range(0, l - 1)) : -1,
                 $urandom_range(0, 11) == 0 ? int'($urandom_range(1, l - 1)) : -1,
                 $urandom_range(0, 3), $urandom_range(0, 2) == 0);
        end
        repeat (100) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_fsm.md
Name: uart_rx_fsm

Overview:
UART receiver for the low-power processing system. It deserialises an 8-bit frame from a single serial line using an oversampling clock. The frame is start bit, data LSB-first, optional parity, one stop bit. The block pairs with the UART transmit path on the far side of the link and hands received bytes, plus error flags, to the register/sync layer.

Parameters:
PRESCALE, 8, clk cycles per serial bit; even, minimum 4.
DATA_WIDTH, 8, data bits per frame.

Ports:
clk  input  1  oversampling clock (PRESCALE × baud).
rest  input  1  synchronous, active-high reset.
rx_in  input  1  serial line, idle high; already synchronised to clk upstream.
par_en  input  1  1 = parity bit present in frame.
par_typ  input  1  0 = even parity, 1 = odd parity.
p_data  output  DATA_WIDTH  last correctly received byte.
data_valid  output  1  one-cycle pulse when p_data updates.
par_err  output  1  one-cycle pulse: parity mismatch in the just-ended frame.
stp_err  output  1  one-cycle pulse: stop bit sampled low.
busy  output  1  high while a frame is in progress (state ≠ IDLE).

Behaviour:
- Reset (rest=1 at posedge clk): state=IDLE, counters=0, p_data=0, data_valid=par_err=stp_err=busy=0. Reset mid-frame aborts the frame; no pulse is generated.
- Counters: edge_cnt runs 0..PRESCALE-1 per bit and wraps to 0. bit_cnt counts data bits 0..DATA_WIDTH-1.
- Sample point: rx_in is sampled when edge_cnt == PRESCALE/2.
- States:
  - IDLE: on rx_in=0 (cycle T0), latch par_en/par_typ, edge_cnt=0, go to START. par_en/par_typ changes during a frame are ignored.
  - START: at the sample point, if rx_in=1 the start was a glitch: return to IDLE with no outputs. At edge_cnt=PRESCALE-1, go to DATA.
  - DATA: at the sample point, shift rx_in into a shift register, LSB first. After bit DATA_WIDTH-1 completes, go to PARITY if the latched par_en=1, else STOP.
  - PARITY: at the sample point, compare rx_in with the computed parity (XOR of data, inverted when odd) and record a mismatch. At end of bit, go to STOP.
  - STOP: at the sample point, record stp = rx_in. At edge_cnt=PRESCALE-1, go to IDLE.
- Outputs are registered in the cycle after the last STOP count. With PRESCALE=8, that is T0+80 without parity and T0+88 with parity.
  - No errors: p_data ← shift register, data_valid=1.
  - Any error: data_valid=0, p_data unchanged; par_err and/or stp_err=1 as applicable. Both may assert together.
- All pulses last exactly one cycle.
- Back-to-back frames: IDLE may detect a new start in the same cycle the pulses assert, so there is no dead cycle.
- busy=1 from the cycle after T0 through the last STOP count.
- rx_in held low continuously: gives stp_err, then a new frame starts immediately (break condition; no special handling).

Optional Feature:
UART_RX_MAJORITY_EN
- Defined: each bit value is the 2-of-3 majority of rx_in at edge_cnt = PRESCALE/2-1, PRESCALE/2, PRESCALE/2+1. The decision is made at PRESCALE/2+1. This applies to the start-glitch check, data, parity and stop bits. Frame latency is unchanged.
- Undefined: single sample at PRESCALE/2, as described above.

Test Plan:
1. PRESCALE=8, par_en=0, send 0xA5 → data_valid pulse at T0+80, p_data=0xA5, par_err=stp_err=0.
2. par_en=1, par_typ=0, send 0x3C with parity bit 0 → p_data=0x3C valid at T0+88. Resend with parity bit 1 → par_err pulse at T0+88, data_valid=0, p_data stays 0x3C.
3. par_en=1, par_typ=1, send 0x01 with stop bit driven 0 and correct parity 0 → stp_err=1, par_err=0, data_valid=0.
4. rx_in low for 3 cycles then high → busy rises and falls, returns to IDLE by T0+5, no pulses. Then a valid 0x55 frame → p_data=0x55.
5. Two frames 0x12, 0x34 with no idle gap → two data_valid pulses 80 cycles apart, p_data=0x12 then 0x34.
6. Assert rest at T0+40 mid-frame → all outputs 0 next cycle. A following 0xFF frame → p_data=0xFF. With UART_RX_MAJORITY_EN, a single-cycle inverted glitch at sample point of bit 3 of 0x00 → p_data=0x00.
